// File: rtl/ceyloniac_instruction_queue.sv
// ceyloniac_instruction_queue: DEPTH-entry fetch FIFO feeding an instruction register with decoded MIPS fields
module ceyloniac_instruction_queue #(
  parameter int DEPTH = 4,
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         fill_valid,
  output logic                         fill_ready,
  input  logic [INSTR_WIDTH-1:0]       fill_instr,
  input  logic [PC_WIDTH-1:0]          fill_pc,
  input  logic                         ir_write,
  output logic                         ir_valid,
  output logic [PC_WIDTH-1:0]          ir_pc,
  output logic [5:0]                   instr_31_26,
  output logic [4:0]                   instr_25_21,
  output logic [4:0]                   instr_20_16,
  output logic [4:0]                   instr_15_11,
  output logic [15:0]                  instr_15_0,
  output logic [25:0]                  instr_25_0,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [INSTR_WIDTH-1:0] ir;
  logic push, pop;
  assign fill_ready = count != CW'(DEPTH);
  assign empty = count == '0;
  assign push = fill_valid && fill_ready;
  assign pop = ir_write && !empty;
  assign instr_31_26 = ir[31:26];
  assign instr_25_21 = ir[25:21];
  assign instr_20_16 = ir[20:16];
  assign instr_15_11 = ir[15:11];
  assign instr_15_0 = ir[15:0];
  assign instr_25_0 = ir[25:0];
  // storage is deliberately left unreset; pointers and count define what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= fill_instr;
      mem_pc[wr_ptr] <= fill_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        ir <= mem_instr[rd_ptr];
        ir_pc <= mem_pc[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (ir_write) ir_valid <= pop;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ceyloniac_instruction_queue.sv
// tb_ceyloniac_instruction_queue: vector table, directed corner sequences and random traffic against a queue model
module tb_ceyloniac_instruction_queue;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset = 0, flush = 0, fill_valid = 0, ir_write = 0;
  logic [31:0] fill_instr = 0, fill_pc = 0;
  logic fill_ready, ir_valid, empty;
  logic [31:0] ir_pc;
  logic [5:0] instr_31_26;
  logic [4:0] instr_25_21, instr_20_16, instr_15_11;
  logic [15:0] instr_15_0;
  logic [25:0] instr_25_0;
  logic [2:0] count;
  int errors = 0, checks = 0;
  logic [63:0] q[$];
  logic [31:0] m_ir = 0, m_pc = 0;
  logic m_valid = 0;

  typedef struct {
    logic r, f, v;
    logic [31:0] i, p;
    logic w;
    logic ev;
    logic [31:0] epc, eir;
    int ec;
  } vec_t;
  vec_t tbl[14];

  ceyloniac_instruction_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_instr(fill_instr), .fill_pc(fill_pc), .ir_write(ir_write), .ir_valid(ir_valid),
    .ir_pc(ir_pc), .instr_31_26(instr_31_26), .instr_25_21(instr_25_21), .instr_20_16(instr_20_16),
    .instr_15_11(instr_15_11), .instr_15_0(instr_15_0), .instr_25_0(instr_25_0),
    .count(count), .empty(empty));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] epc, input logic [31:0] eir, input int ec);
    chk({tag, " ir_valid"}, 64'(ir_valid), 64'(ev));
    chk({tag, " ir_pc"}, 64'(ir_pc), 64'(epc));
    chk({tag, " instr_31_26"}, 64'(instr_31_26), 64'(eir[31:26]));
    chk({tag, " instr_25_21"}, 64'(instr_25_21), 64'(eir[25:21]));
    chk({tag, " instr_20_16"}, 64'(instr_20_16), 64'(eir[20:16]));
    chk({tag, " instr_15_11"}, 64'(instr_15_11), 64'(eir[15:11]));
    chk({tag, " instr_15_0"}, 64'(instr_15_0), 64'(eir[15:0]));
    chk({tag, " instr_25_0"}, 64'(instr_25_0), 64'(eir[25:0]));
    chk({tag, " count"}, 64'(count), 64'(ec));
    chk({tag, " empty"}, 64'(empty), 64'(ec == 0));
    chk({tag, " fill_ready"}, 64'(fill_ready), 64'(ec < DEPTH));
  endtask

  // reference: an unbounded queue limited to DEPTH, decisions taken on the pre-edge occupancy
  task automatic model(input logic r, f, v, input logic [31:0] i, p, input logic w);
    int n;
    logic [63:0] e;
    if (r || f) begin
      q.delete();
      m_ir = 0;
      m_pc = 0;
      m_valid = 0;
    end else begin
      n = q.size();
      if (w) begin
        if (n > 0) begin
          e = q.pop_front();
          m_ir = e[31:0];
          m_pc = e[63:32];
          m_valid = 1;
        end else m_valid = 0;
      end
      if (v && n < DEPTH) q.push_back({p, i});
    end
  endtask

  task automatic step(input string tag, input logic r, f, v, input logic [31:0] i, p, input logic w);
    reset = r; flush = f; fill_valid = v; fill_instr = i; fill_pc = p; ir_write = w;
    @(posedge clk);
    model(r, f, v, i, p, w);
    #1;
    check_all(tag, m_valid, m_pc, m_ir, q.size());
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h0,        32'h0,   0, 0, 32'h0,   32'h0,        0};
    tbl[1]  = '{0, 0, 1, 32'h8C220004, 32'h100, 0, 0, 32'h0,   32'h0,        1};
    tbl[2]  = '{0, 0, 0, 32'h0,        32'h0,   0, 0, 32'h0,   32'h0,        1};
    tbl[3]  = '{0, 0, 0, 32'h0,        32'h0,   1, 1, 32'h100, 32'h8C220004, 0};
    tbl[4]  = '{0, 0, 1, 32'h1,        32'h204, 0, 1, 32'h100, 32'h8C220004, 1};
    tbl[5]  = '{0, 0, 1, 32'h2,        32'h208, 0, 1, 32'h100, 32'h8C220004, 2};
    tbl[6]  = '{0, 0, 1, 32'h3,        32'h20C, 0, 1, 32'h100, 32'h8C220004, 3};
    tbl[7]  = '{0, 0, 1, 32'h4,        32'h210, 0, 1, 32'h100, 32'h8C220004, 4};
    tbl[8]  = '{0, 0, 1, 32'h5,        32'h214, 0, 1, 32'h100, 32'h8C220004, 4};
    tbl[9]  = '{0, 0, 0, 32'h0,        32'h0,   1, 1, 32'h204, 32'h1,        3};
    tbl[10] = '{0, 0, 0, 32'h0,        32'h0,   1, 1, 32'h208, 32'h2,        2};
    tbl[11] = '{0, 0, 0, 32'h0,        32'h0,   1, 1, 32'h20C, 32'h3,        1};
    tbl[12] = '{0, 0, 0, 32'h0,        32'h0,   1, 1, 32'h210, 32'h4,        0};
    tbl[13] = '{0, 0, 0, 32'h0,        32'h0,   1, 0, 32'h210, 32'h4,        0};
    for (int k = 0; k < 14; k++) begin
      step($sformatf("model row%0d", k), tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].w);
      check_all($sformatf("table row%0d", k), tbl[k].ev, tbl[k].epc, tbl[k].eir, tbl[k].ec);
    end
    // steady state at count=2 with push and pop every cycle across pointer wrap
    step("wrap reset", 1, 0, 0, 0, 0, 0);
    step("wrap pre0", 0, 0, 1, 32'hA0, 32'h300, 0);
    step("wrap pre1", 0, 0, 1, 32'hA1, 32'h304, 0);
    for (int k = 2; k < 12; k++) begin
      step($sformatf("wrap%0d", k), 0, 0, 1, 32'hA0 + k, 32'h300 + 4 * k, 1);
      chk("wrap count", 64'(count), 64'd2);
      chk("wrap order", 64'(ir_pc), 64'(32'h300 + 4 * (k - 2)));
    end
    // push and pop into an empty queue do not bypass
    step("nobypass reset", 1, 0, 0, 0, 0, 0);
    step("nobypass same", 0, 0, 1, 32'h0800000A, 32'h400, 1);
    chk("nobypass ir_valid", 64'(ir_valid), 64'd0);
    step("nobypass next", 0, 0, 0, 0, 0, 1);
    chk("nobypass target", 64'(instr_25_0), 64'h000000A);
    chk("nobypass count", 64'(count), 64'd0);
    // flush beats a concurrent fill
    for (int k = 0; k < 4; k++) step("flush fill", 0, 0, 1, 32'hB0 + k, 32'h500 + 4 * k, 0);
    step("flush pop", 0, 0, 0, 0, 0, 1);
    chk("flush pre count", 64'(count), 64'd3);
    step("flush", 0, 1, 1, 32'hDEADBEEF, 32'h600, 0);
    chk("flush count", 64'(count), 64'd0);
    chk("flush fields", 64'({instr_31_26, instr_25_0}), 64'd0);
    step("flush after", 0, 0, 0, 0, 0, 1);
    chk("flush dropped", 64'(ir_valid), 64'd0);
    // reset mid-stream overrides a pop
    for (int k = 0; k < 3; k++) step("rst fill", 0, 0, 1, 32'hC0 + k, 32'h700 + 4 * k, 0);
    step("rst mid", 1, 0, 0, 0, 0, 1);
    chk("rst ready", 64'(fill_ready), 64'd1);
    step("rst after", 0, 0, 0, 0, 0, 1);
    chk("rst ir_valid", 64'(ir_valid), 64'd0);
    for (int k = 0; k < 2000; k++)
      step("rand", $urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(9) < 6,
           $urandom, $urandom, $urandom_range(1) == 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
